dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for the 5-stage core's MEM-stage port. Decodes the core's
//  mem_w / DMType / address / write-data and returns load data in the same cycle,
//  already sign- or zero-extended. Backing store is word-organised RAM with byte
//  lanes, plus a small MMIO window holding an LED register, a free-running cycle
//  counter and a misaligned-store counter.
// PARAMETERS
//  DEPTH_WORDS  1024           RAM depth in 32-bit words (power of 2); RAM spans 0 .. DEPTH_WORDS*4-1
//  MMIO_BASE    32'hFFFF_0000  base address of the MMIO window (64 KB aligned)
//  LED_W        16             width of the LED register
// PORTS
//  clk           in   1      clock
//  reset         in   1      synchronous, active-high
//  mem_w         in   1      store strobe, qualified valid by the core
//  dm_type       in   3      000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
//  addr          in   32     byte address
//  wdata         in   32     store data; the low bytes are used for sub-word stores
//  rdata         out  32     load data (combinational), extended per dm_type
//  led           out  LED_W  LED register
//  misalign_err  out  1      sticky flag, set by the first misaligned store
//  dbg_addr      in   32     debug word-read address (byte address, bits [1:0] ignored)
//  dbg_data      out  32     raw RAM word at dbg_addr (combinational), 0 if out of range
// BEHAVIOUR
//  - Reset: led=0, cycle_cnt=0, misalign_cnt=0, misalign_err=0. RAM contents are NOT cleared.
//  - Read path is fully combinational with zero latency; the core samples rdata in the same cycle.
//    A load in the same cycle as a store to the same word returns the OLD contents.
//  - Stores commit on the clk edge when mem_w=1 and reset=0. New data is readable the next cycle.
//  - RAM hit: addr < DEPTH_WORDS*4. Word index = addr[clog2(DEPTH_WORDS)+1:2].
//    - byte: lane addr[1:0] <= wdata[7:0]. half: lanes {addr[1],0}/+1 <= wdata[15:0].
//    - word: all lanes. Lanes that are not written keep their values.
//  - Load extraction selects the same lanes, shifts them to bit 0, then:
//    - 000: word as is. 001: sign-extend bit 15. 010: zero-extend.
//    - 011: sign-extend bit 7. 100: zero-extend.
//    - Codes 101-111: treated as word for reads; stores with these codes are ignored.
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
//    - A misaligned store is dropped, misalign_cnt increments (saturating at 32'hFFFF_FFFF),
//      and misalign_err sets (cleared only by reset).
//    - A misaligned load returns 0 and has no side effects.
//  - MMIO hit: addr[31:16]==MMIO_BASE[31:16]. Word registers only; sub-word access reads 0 and writes are ignored.
//    - +0x0 LED: RW, led <= wdata[LED_W-1:0]; reads are zero-extended.
//    - +0x4 CYCLE: RO counter, +1 every non-reset cycle, wraps 2^32-1 -> 0.
//      A store loads wdata and takes precedence over that cycle's increment; the next cycle reads wdata.
//    - +0x8 MISALIGN: count of dropped stores. Any word store clears it to 0; a simultaneous increment is lost.
//    - Other offsets read 0; writes to them are ignored.
//  - Unmapped addresses (neither RAM nor MMIO) read 0; writes to them are ignored, with no error.
//  - Reset asserted in the same cycle as mem_w: the store is discarded and registers take their reset values.
// TESTING
//  1. sw 0x8765_4321 @0x10; next cycle lw/lh/lhu/lb/lbu @0x10,0x12,0x13
//     -> 87654321, 00004321, 00008765, 00000087(lbu@0x13), FFFFFF87(lb@0x13).
//  2. sb 0xAA @0x21 over word 0x11223344 @0x20 -> lw @0x20 = 0x1122AA44; sh 0xBEEF @0x22 -> 0xBEEFAA44.
//  3. sh @0x31 and sw @0x32 -> RAM unchanged, MISALIGN reads 2, misalign_err=1;
//     sw @MMIO_BASE+8 -> reads 0, misalign_err stays 1.
//  4. After reset, N cycles -> CYCLE reads N-1..N (match the bench's sampling point);
//     sw 0xFFFF_FFFE to CYCLE -> next cycle reads FFFFFFFE, then FFFFFFFF, then 0.
//  5. sw 0x0001_ABCD to LED -> led=0xABCD, lw LED = 0x0000ABCD;
//     sb to LED -> led unchanged; lw @0x0001_0000 (unmapped, DEPTH=1024) -> 0.
//  6. Same-cycle sw 0x5 and lw @0x40 (old 0x9) -> rdata=0x9, next cycle 0x5;
//     reset held with mem_w=1 -> store discarded; led, CYCLE and MISALIGN read 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory target for the core's MEM stage: combinational load path with byte-lane RAM,
// plus an MMIO window holding LED, free-running cycle counter and misaligned-store counter.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_mem_w,
    input  logic [2:0]       i_dm_type,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic [LED_W-1:0] o_led,
    output logic             o_misalign_err,
    input  logic [31:0]      i_dbg_addr,
    output logic [31:0]      o_dbg_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_cycle_cnt;
    logic [31:0]      r_misalign_cnt;
    logic             r_misalign_err;

    logic          w_is_word, w_is_half, w_is_byte, w_store_type_ok;
    logic          w_misaligned, w_ram_hit, w_mmio_hit;
    logic [AW-1:0] w_word_idx;
    logic          w_store, w_store_ok, w_store_bad;
    logic          w_ram_we, w_mmio_we, w_led_we, w_cycle_we, w_misalign_clr;
    logic [15:0]   w_mmio_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_ram_word, w_shifted, w_ram_rdata, w_mmio_rdata, w_led_ext;
    logic          w_dbg_hit;
    logic          w_unused_dbg;

    // Codes 101-111 behave as word for reads; only 000-100 are legal store codes.
    assign w_is_word       = (i_dm_type == 3'b000) || (i_dm_type > 3'b100);
    assign w_is_half       = (i_dm_type == 3'b001) || (i_dm_type == 3'b010);
    assign w_is_byte       = (i_dm_type == 3'b011) || (i_dm_type == 3'b100);
    assign w_store_type_ok = (i_dm_type <= 3'b100);

    assign w_misaligned = (w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00));
    assign w_ram_hit    = (i_addr < RAM_BYTES);
    assign w_mmio_hit   = !w_ram_hit && (i_addr[31:16] == MMIO_BASE[31:16]);
    assign w_word_idx   = i_addr[AW+1:2];
    assign w_mmio_off   = i_addr[15:0];

    assign w_store        = i_mem_w && w_store_type_ok;
    assign w_store_ok     = w_store && !w_misaligned;
    assign w_store_bad    = w_store && w_misaligned;
    assign w_ram_we       = w_store_ok && w_ram_hit;
    assign w_mmio_we      = w_store_ok && w_mmio_hit && w_is_word;
    assign w_led_we       = w_mmio_we && (w_mmio_off == 16'h0000);
    assign w_cycle_we     = w_mmio_we && (w_mmio_off == 16'h0004);
    assign w_misalign_clr = w_mmio_we && (w_mmio_off == 16'h0008);

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = i_wdata;
        if (w_is_word) begin
            w_be = 4'b1111;
        end else if (w_is_half) begin
            w_be     = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{i_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_be     = 4'b0001 << i_addr[1:0];
            w_wlanes = {4{i_wdata[7:0]}};
        end
    end

    // RAM is deliberately not reset; only the enabled lanes are overwritten.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_word_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led          <= '0;
            r_cycle_cnt    <= '0;
            r_misalign_cnt <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            if (w_led_we) r_led <= i_wdata[LED_W-1:0];
            r_cycle_cnt <= w_cycle_we ? i_wdata : r_cycle_cnt + 32'd1;
            if (w_misalign_clr) begin
                r_misalign_cnt <= '0;
            end else if (w_store_bad && (r_misalign_cnt != 32'hFFFF_FFFF)) begin
                r_misalign_cnt <= r_misalign_cnt + 32'd1;
            end
            if (w_store_bad) r_misalign_err <= 1'b1;
        end
    end

    // Aligned accesses make a single byte shift correct for every access size.
    assign w_ram_word = r_mem[w_word_idx];
    assign w_shifted  = w_ram_word >> {i_addr[1:0], 3'b000};

    always_comb begin
        case (i_dm_type)
            3'b001:  w_ram_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_ram_rdata = {16'h0000, w_shifted[15:0]};
            3'b011:  w_ram_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ram_rdata = {24'h000000, w_shifted[7:0]};
            default: w_ram_rdata = w_ram_word;
        endcase
    end

    always_comb begin
        w_led_ext              = '0;
        w_led_ext[LED_W-1:0]   = r_led;
    end

    always_comb begin
        w_mmio_rdata = 32'h0;
        if (w_is_word) begin
            case (w_mmio_off)
                16'h0000: w_mmio_rdata = w_led_ext;
                16'h0004: w_mmio_rdata = r_cycle_cnt;
                16'h0008: w_mmio_rdata = r_misalign_cnt;
                default:  w_mmio_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        o_rdata = 32'h0;
        if (!w_misaligned) begin
            if (w_ram_hit)       o_rdata = w_ram_rdata;
            else if (w_mmio_hit) o_rdata = w_mmio_rdata;
        end
    end

    assign w_dbg_hit    = (i_dbg_addr < RAM_BYTES);
    assign o_dbg_data   = w_dbg_hit ? r_mem[i_dbg_addr[AW+1:2]] : 32'h0;
    assign w_unused_dbg = ^i_dbg_addr[1:0];

    assign o_led          = r_led;
    assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_w = 1'b0;
  logic [2:0]  dm_type = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] dbg_addr = 32'h0;
  logic [31:0] rdata, dbg_data;
  logic [15:0] led;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state: first 256 bytes of RAM plus the MMIO registers.
  logic [7:0]  m_bytes [256];
  logic [15:0] m_led = '0;
  logic [31:0] m_cycle = '0;
  logic [31:0] m_mis = '0;
  logic        m_err = 1'b0;

  dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MMIO), .LED_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_mem_w        (mem_w),
    .i_dm_type      (dm_type),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_led          (led),
    .o_misalign_err (misalign_err),
    .i_dbg_addr     (dbg_addr),
    .o_dbg_data     (dbg_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int base = int'(a[7:0]) & ~3;
    for (int k = 0; k < 4; k++) v = v | (32'(m_bytes[base + k]) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] t, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int sz = size_of(t);
    if ((a % sz) != 0) return 32'h0;
    if (a < 32'd4096) begin
      for (int k = 0; k < sz; k++) v = v | (32'(m_bytes[int'(a[7:0]) + k]) << (8 * k));
      if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
      return v;
    end
    if (a[31:16] == MMIO[31:16] && sz == 4) begin
      if (a[15:0] == 16'h0) return {16'h0, m_led};
      if (a[15:0] == 16'h4) return m_cycle;
      if (a[15:0] == 16'h8) return m_mis;
    end
    return 32'h0;
  endfunction

  // Model update: later nonblocking writes override the default increment.
  always @(posedge clk) begin
    if (reset) begin
      m_led   <= '0;
      m_cycle <= '0;
      m_mis   <= '0;
      m_err   <= 1'b0;
    end else begin
      m_cycle <= m_cycle + 32'd1;
      if (mem_w && dm_type <= 3'd4) begin
        if ((addr % size_of(dm_type)) != 0) begin
          m_err <= 1'b1;
          if (m_mis != 32'hFFFF_FFFF) m_mis <= m_mis + 32'd1;
        end else if (addr < 32'd256) begin
          for (int k = 0; k < size_of(dm_type); k++)
            m_bytes[int'(addr[7:0]) + k] <= wdata[8*k +: 8];
        end else if (addr[31:16] == MMIO[31:16] && size_of(dm_type) == 4) begin
          if (addr[15:0] == 16'h0) m_led <= wdata[15:0];
          if (addr[15:0] == 16'h4) m_cycle <= wdata;
          if (addr[15:0] == 16'h8) m_mis <= 32'h0;
        end
      end
    end
  end

  // Per-cycle scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("rdata", rdata, model_read(dm_type, addr));
      check("led", {16'h0, led}, {16'h0, m_led});
      check("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
      if (dbg_addr < 32'd4096) check("dbg_data", dbg_data, model_word(dbg_addr));
      else                     check("dbg_data_oor", dbg_data, 32'h0);
    end
  end

  // Driver: one bus cycle, optional literal check of rdata mid-cycle.
  task automatic cyc(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                     input bit chk = 1'b0, input string name = "", input logic [31:0] exp = 32'h0);
    mem_w = w; dm_type = t; addr = a; wdata = d;
    @(negedge clk);
    if (chk) check(name, rdata, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int r;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) cyc(1'b1, 3'd0, 32'(4 * i), $urandom);
    chk_en = 1'b1;

    // load extraction
    cyc(1, 0, 32'h10, 32'h8765_4321);
    cyc(0, 0, 32'h10, 0, 1, "lw_10", 32'h8765_4321);
    cyc(0, 1, 32'h10, 0, 1, "lh_10", 32'h0000_4321);
    cyc(0, 2, 32'h12, 0, 1, "lhu_12", 32'h0000_8765);
    cyc(0, 4, 32'h13, 0, 1, "lbu_13", 32'h0000_0087);
    cyc(0, 3, 32'h13, 0, 1, "lb_13", 32'hFFFF_FF87);

    // partial stores keep other lanes
    cyc(1, 0, 32'h20, 32'h1122_3344);
    cyc(1, 3, 32'h21, 32'h0000_00AA);
    cyc(0, 0, 32'h20, 0, 1, "sb_merge", 32'h1122_AA44);
    cyc(1, 1, 32'h22, 32'h0000_BEEF);
    cyc(0, 0, 32'h20, 0, 1, "sh_merge", 32'hBEEF_AA44);

    // misaligned stores
    cyc(1, 0, 32'h30, 32'h0BAD_F00D);
    cyc(1, 1, 32'h31, 32'hFFFF_FFFF);
    cyc(1, 0, 32'h32, 32'h1234_5678);
    cyc(0, 0, 32'h30, 0, 1, "misalign_drop", 32'h0BAD_F00D);
    cyc(0, 0, MMIO + 8, 0, 1, "misalign_cnt2", 32'd2);
    check("misalign_err_set", {31'h0, misalign_err}, 32'd1);
    cyc(1, 0, MMIO + 8, 32'hFFFF_FFFF);
    cyc(0, 0, MMIO + 8, 0, 1, "misalign_clr", 32'd0);
    check("misalign_err_sticky", {31'h0, misalign_err}, 32'd1);

    // LED and unmapped
    cyc(1, 0, MMIO, 32'h0001_ABCD);
    check("led_write", {16'h0, led}, 32'h0000_ABCD);
    cyc(0, 0, MMIO, 0, 1, "led_read", 32'h0000_ABCD);
    cyc(1, 3, MMIO, 32'h0000_0055);
    check("led_subword_ignored", {16'h0, led}, 32'h0000_ABCD);
    cyc(0, 0, 32'h0001_0000, 0, 1, "unmapped", 32'h0);

    // read-before-write in the same cycle
    cyc(1, 0, 32'h40, 32'h9);
    cyc(1, 0, 32'h40, 32'h5, 1, "same_cycle_old", 32'h9);
    cyc(0, 0, 32'h40, 0, 1, "next_cycle_new", 32'h5);

    // reset with a pending store; counters from reset
    cyc(1, 0, 32'h44, 32'h4444_4444);
    reset = 1'b1;
    cyc(1, 0, MMIO, 32'h0000_1234);
    cyc(1, 0, 32'h44, 32'hDEAD_BEEF);
    reset = 1'b0;
    cyc(0, 0, MMIO + 4, 0, 1, "cycle_after_reset", 32'd0);
    check("led_reset", {16'h0, led}, 32'h0);
    check("err_reset", {31'h0, misalign_err}, 32'h0);
    cyc(0, 0, MMIO, 0, 1, "led_read_reset", 32'h0);
    cyc(0, 0, MMIO + 8, 0, 1, "mis_read_reset", 32'h0);
    cyc(0, 0, 32'h44, 0, 1, "store_in_reset_dropped", 32'h4444_4444);
    for (int i = 4; i < 8; i++) cyc(0, 0, MMIO + 4, 0);
    cyc(0, 0, MMIO + 4, 0, 1, "cycle_n8", 32'd8);
    cyc(1, 0, MMIO + 4, 32'hFFFF_FFFE);
    cyc(0, 0, MMIO + 4, 0, 1, "cycle_load", 32'hFFFF_FFFE);
    cyc(0, 0, MMIO + 4, 0, 1, "cycle_max", 32'hFFFF_FFFF);
    cyc(0, 0, MMIO + 4, 0, 1, "cycle_wrap", 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      a = 32'($urandom_range(0, 255));
      else if (r < 85) a = MMIO + 32'($urandom_range(0, 4) * 4);
      else if (r < 97) a = 32'h0000_1000 + 32'($urandom_range(0, 1023) * 4);
      else             a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) dbg_addr = 32'($urandom_range(0, 255));
      else                           dbg_addr = $urandom | 32'h0000_1000;
      reset = (r >= 98);
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
